// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect input and
// decode-side valid/ready head of the prefetch queue.
interface fetch_prefetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          ifid_valid;
  logic          ifid_ready;
  logic [31:0]   ifid_instr;
  logic [31:0]   ifid_pc;
  logic [31:0]   ifid_pcp4;
  logic [CW-1:0] fifo_count;

  modport master (
    output imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pcp4, fifo_count,
    input  imem_rvalid, imem_rdata, redirect, redirect_pc, ifid_ready
  );

  modport slave (
    input  imem_req, imem_addr, ifid_valid, ifid_instr, ifid_pc, ifid_pcp4, fifo_count,
    output imem_rvalid, imem_rdata, redirect, redirect_pc, ifid_ready
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word fetches and
// buffers returned instructions with their PC in a small FIFO feeding IF/ID.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fetch_prefetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          req;
  logic          enq;
  logic          deq;
  logic          head_valid;
  logic [CW:0]   occupancy;

  // Credit counts the outstanding fetch so its response always has a free slot.
  always_comb begin
    occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
    head_valid = (count != '0);
    req        = (state == FETCH) && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
    enq        = (state == FETCH) && bus.imem_rvalid && inflight && !bus.redirect;
    deq        = head_valid && bus.ifid_ready && !bus.redirect;
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.ifid_valid = head_valid && !bus.redirect;
  assign bus.ifid_instr = head_valid ? instr_mem[rd_ptr] : '0;
  assign bus.ifid_pc    = head_valid ? pc_mem[rd_ptr] : '0;
  assign bus.ifid_pcp4  = head_valid ? pc_mem[rd_ptr] + 32'd4 : '0;
  assign bus.fifo_count = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.redirect) begin
            // Flush wins over stall and response; the in-flight word is discarded.
            fetch_pc <= bus.redirect_pc & ~32'h3;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
          end else begin
            if (req) begin
              req_pc   <= fetch_pc;
              fetch_pc <= fetch_pc + 32'd4;
            end
            inflight <= req;
            if (enq) begin
              instr_mem[wr_ptr] <= bus.imem_rdata;
              pc_mem[wr_ptr]    <= req_pc;
              wr_ptr            <= wr_ptr + PW'(1);
            end
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            unique case ({enq, deq})
              2'b10:   count <= count + CW'(1);
              2'b01:   count <= count - CW'(1);
              default: count <= count;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench: a transaction-level model of the fetch stream predicts request
// addresses and the decode-side instruction stream; a negedge monitor compares.
module tb_fetch_prefetch_queue;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_prefetch_queue_if #(.DEPTH(DEPTH)) busw ();

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(busw)
  );

  int err = 0;
  int chk = 0;
  int cycles = 0;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memories: answer exactly one cycle after a sampled request.
  logic        req_s, reqw_s, spur_en = 1'b0;
  logic [31:0] addr_s, addrw_s;
  initial begin
    bus.imem_rvalid = 1'b0;  bus.imem_rdata = '0;
    busw.imem_rvalid = 1'b0; busw.imem_rdata = '0;
    busw.redirect = 1'b0;    busw.redirect_pc = '0; busw.ifid_ready = 1'b1;
  end
  always @(posedge clk) begin
    bus.imem_rvalid  <= (req_s === 1'b1) || (spur_en && ($urandom_range(0, 7) == 0));
    bus.imem_rdata   <= imem_word(addr_s);
    busw.imem_rvalid <= (reqw_s === 1'b1);
    busw.imem_rdata  <= imem_word(addrw_s);
  end

  // Reference model state (value after the latest clock edge).
  entry_t      q[$];
  bit          chk_en = 0, running = 0, m_inflight = 0, m_req_now = 0, just_reset = 0;
  logic [31:0] m_pc = '0, m_req_pc = '0;

  always @(posedge clk) begin
    cycles++;
    if (!rst_n) begin
      q.delete();
      running = 0; m_inflight = 0; m_pc = 32'h0; just_reset = 1; chk_en = 1;
    end else if (!running) begin
      running = 1; just_reset = 0;
    end else if (bus.redirect) begin
      q.delete();
      m_inflight = 0; m_pc = bus.redirect_pc & ~32'h3;
    end else begin
      if (bus.imem_rvalid && m_inflight) q.push_back('{imem_word(m_req_pc), m_req_pc});
      if (m_req_now) begin
        m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_inflight = 1;
      end else m_inflight = 0;
    end
  end

  // Monitor for the main instance.
  always @(negedge clk) begin
    req_s = bus.imem_req; addr_s = bus.imem_addr;
    if (chk_en) begin
      automatic int sz = q.size();
      automatic bit exp_req = running && !bus.redirect && (sz + int'(m_inflight) < DEPTH);
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
      check("ifid_valid", 32'(bus.ifid_valid), 32'(sz != 0 && !bus.redirect));
      check("fifo_count", 32'(bus.fifo_count), sz);
      if (sz != 0) begin
        check("ifid_instr", bus.ifid_instr, q[0].instr);
        check("ifid_pc", bus.ifid_pc, q[0].pc);
        check("ifid_pcp4", bus.ifid_pcp4, q[0].pc + 32'd4);
        if (bus.ifid_ready && !bus.redirect) void'(q.pop_front());
      end else if (just_reset) begin
        check("reset_instr", bus.ifid_instr, 32'h0);
        check("reset_pc", bus.ifid_pc, 32'h0);
      end
      m_req_now = exp_req;
    end
  end

  // Monitor for the wrap-around instance: free-running, always ready.
  logic [31:0] w_addr = WRAP_PC, w_pc = WRAP_PC;
  bit          w_seen_fffc = 0;
  always @(negedge clk) begin
    reqw_s = busw.imem_req; addrw_s = busw.imem_addr;
    if (!rst_n) begin
      w_addr = WRAP_PC; w_pc = WRAP_PC;
    end else if (chk_en) begin
      if (busw.imem_req) begin
        check("wrap_addr", busw.imem_addr, w_addr);
        w_addr = w_addr + 32'd4;
      end
      if (busw.ifid_valid) begin
        check("wrap_pc", busw.ifid_pc, w_pc);
        check("wrap_pcp4", busw.ifid_pcp4, w_pc + 32'd4);
        check("wrap_instr", busw.ifid_instr, imem_word(w_pc));
        if (w_pc == 32'hFFFFFFFC) w_seen_fffc = 1;
        w_pc = w_pc + 32'd4;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input int n);
    int k = 0;
    while (bus.fifo_count != n && k < 40) begin
      tick();
      k++;
    end
    chk++;
    if (bus.fifo_count != n) begin
      err++;
      $display("FAIL wait_count: got %0d expected %0d", bus.fifo_count, n);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect = 1'b1; bus.redirect_pc = pc;
    tick();
    bus.redirect = 1'b0;
  endtask

  initial begin
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.ifid_ready = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);                                  // sustained streaming from 0
    bus.ifid_ready = 1'b0;
    tick(12);                                  // fills to DEPTH, requests stop
    bus.ifid_ready = 1'b1;
    tick(10);

    bus.ifid_ready = 1'b0;
    redirect_to(32'h40);
    wait_count(3);                             // last fetch still in flight
    redirect_to(32'h100);
    check("count_after_redirect", 32'(bus.fifo_count), 32'h0);
    bus.ifid_ready = 1'b1;
    tick(8);

    redirect_to(32'h203);                      // misaligned target
    tick(6);
    bus.redirect = 1'b1; bus.redirect_pc = 32'h500;
    tick();
    bus.redirect_pc = 32'h600;                 // back-to-back: last wins
    tick();
    bus.redirect = 1'b0;
    tick(6);
    redirect_to(32'hFFFFFFF0);
    tick(8);

    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.ifid_ready  = ($urandom_range(0, 9) < 7);
      bus.redirect    = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = $urandom;
      tick();
    end
    bus.redirect = 1'b0; bus.ifid_ready = 1'b1;
    spur_en = 1'b0;
    tick(5);

    bus.ifid_ready = 1'b0;
    redirect_to(32'h80);
    wait_count(2);
    rst_n = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'h900;
    tick();
    bus.redirect = 1'b0;
    tick();
    check("reset_count", 32'(bus.fifo_count), 32'h0);
    check("reset_req", 32'(bus.imem_req), 32'h0);
    rst_n = 1'b1;
    check("idle_req", 32'(bus.imem_req), 32'h0);
    bus.ifid_ready = 1'b1;
    tick(12);

    chk++;
    if (!w_seen_fffc) begin
      err++;
      $display("FAIL wrap_seen: got 0 expected 1");
    end
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #100000;
    err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", err, chk);
    $fatal(1, "timeout");
  end
endmodule
